// File: rtl/debug_ocimem_ctrl.sv
// Debug monitor memory controller: arbitrates the on-chip monitor RAM between
// JTAG debug-slave strobes (strict priority) and the CPU Avalon-MM slave port.
module debug_ocimem_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      J_RD = 2'd1,
      C_RD = 2'd2
   } state_t;

   state_t            state_r;
   logic [9:0]        mon_a_r;
   logic              jrd_pend_r;
   logic              jwr_pend_r;
   logic [31:0]       jwr_data_r;
   logic [31:0]       mon_d_r;
   logic              ready_r;
   logic              error_r;
   logic [31:0]       q_r;
   logic [31:0]       mem_r [DEPTH];

   logic              busy_s;
   logic              in_range_s;
   logic              jwr_s;
   logic              jrd_s;
   logic              cwr_s;
   logic              crd_s;
   logic              ram_re_s;
   logic [3:0]        ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [31:0]       ram_wdata_s;

   // Arbitration and single RAM port steering; one access per cycle at most.
   always_comb begin
      busy_s      = jrd_pend_r | jwr_pend_r | (state_r == J_RD);
      in_range_s  = ((mon_a_r >> ADDR_W) == 10'd0);
      jwr_s       = (state_r == IDLE) & jwr_pend_r;
      jrd_s       = (state_r == IDLE) & ~jwr_pend_r & jrd_pend_r;
      cwr_s       = (state_r == IDLE) & ~jwr_pend_r & ~jrd_pend_r & avs_write;
      crd_s       = (state_r == IDLE) & ~jwr_pend_r & ~jrd_pend_r & ~avs_write & avs_read;
      ram_re_s    = jrd_s | crd_s;
      ram_wdata_s = avs_writedata;
      ram_addr_s  = avs_address;
      ram_we_s    = 4'h0;
      if (jwr_s) begin
         ram_wdata_s = jwr_data_r;
         ram_addr_s  = mon_a_r[ADDR_W-1:0];
         ram_we_s    = in_range_s ? 4'hF : 4'h0;
      end else if (jrd_s) begin
         ram_addr_s  = mon_a_r[ADDR_W-1:0];
      end else if (cwr_s) begin
         ram_we_s    = avs_byteenable;
      end else begin
         ram_we_s    = 4'h0;
      end
      if (!reset_n) begin
         avs_waitrequest = 1'b1;
      end else if (cwr_s || (state_r == C_RD)) begin
         avs_waitrequest = 1'b0;
      end else begin
         avs_waitrequest = 1'b1;
      end
   end

   // Monitor RAM array with byte-lane writes; contents survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we_s[b]) begin
            mem_r[ram_addr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
         end
      end
   end

   // RAM read output register, shared by the JTAG and CPU read paths.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_r <= 32'd0;
      end else if (ram_re_s) begin
         q_r <= mem_r[ram_addr_s];
      end else begin
         q_r <= q_r;
      end
   end

   // Control FSM plus JTAG strobe capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         mon_a_r    <= 10'd0;
         jrd_pend_r <= 1'b0;
         jwr_pend_r <= 1'b0;
         jwr_data_r <= 32'd0;
         mon_d_r    <= 32'd0;
         ready_r    <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (jwr_pend_r) begin
                  if (!in_range_s) error_r <= 1'b1;
                  mon_a_r    <= mon_a_r + 10'd1;
                  jwr_pend_r <= 1'b0;
               end else if (jrd_pend_r) begin
                  jrd_pend_r <= 1'b0;
                  state_r    <= J_RD;
               end else if (crd_s) begin
                  state_r    <= C_RD;
               end else begin
                  state_r    <= IDLE;
               end
            end
            J_RD: begin
               mon_d_r <= in_range_s ? q_r : 32'd0;
               if (!in_range_s) error_r <= 1'b1;
               ready_r <= 1'b1;
               mon_a_r <= mon_a_r + 10'd1;
               state_r <= IDLE;
            end
            C_RD: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase

         // The FSM never touches JTAG registers in a cycle where a strobe is accepted.
         if (busy_s) begin
            if (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)
               error_r <= 1'b1;
         end else if (take_action_ocimem_a) begin
            mon_a_r    <= jdo[35:26];
            ready_r    <= 1'b0;
            error_r    <= take_action_ocimem_b;
            jrd_pend_r <= jdo[17];
         end else if (take_action_ocimem_b) begin
            jwr_data_r <= jdo[34:3];
            jwr_pend_r <= 1'b1;
         end else if (take_no_action_ocimem_a) begin
            jrd_pend_r <= 1'b1;
            ready_r    <= 1'b0;
         end else begin
            jwr_pend_r <= jwr_pend_r & ~jwr_s;
         end
      end
   end

   assign avs_readdata  = q_r;
   assign MonDReg       = mon_d_r;
   assign monitor_ready = ready_r;
   assign monitor_error = error_r;

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Directed self-checking bench for debug_ocimem_ctrl (ADDR_W = 8).
module tb_debug_ocimem_ctrl;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        take_no_action_ocimem_a;
   logic [7:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;

   int tests_run = 0;
   int tests_failed = 0;

   debug_ocimem_ctrl #(.ADDR_W(8)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] jdo_a(input logic [9:0] addr, input logic rd);
      return {2'b00, addr, 8'h00, rd, 17'h00000};
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] data);
      return {3'b000, data, 3'b000};
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic pulse(input logic a, input logic b, input logic nb, input logic [37:0] v);
      jdo = v;
      take_action_ocimem_a = a;
      take_action_ocimem_b = b;
      take_no_action_ocimem_a = nb;
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int stalls);
      avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
      stalls = 0;
      #1;
      while (avs_waitrequest && stalls < 20) begin
         @(negedge clk); #1; stalls++;
      end
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int stalls);
      avs_address = a; avs_read = 1'b1;
      stalls = 0;
      #1;
      while (avs_waitrequest && stalls < 20) begin
         @(negedge clk); #1; stalls++;
      end
      d = avs_readdata;
      @(negedge clk);
      avs_read = 1'b0;
   endtask

   initial begin
      int          st;
      logic [31:0] rd;

      reset_n = 1'b0; jdo = 38'd0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      avs_address = 8'd0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = 32'd0; avs_byteenable = 4'h0;
      #2;
      chk("rst_wait", {31'd0, avs_waitrequest}, 32'd1);
      chk("rst_mondreg", MonDReg, 32'd0);
      chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
      chk("rst_error", {31'd0, monitor_error}, 32'd0);
      chk("rst_readdata", avs_readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Preload via CPU
      cpu_write(8'd5, 32'hDEADBEEF, 4'hF, st);  chk("wr5_stall", 32'(st), 32'd0);
      cpu_write(8'd6, 32'hCAFEF00D, 4'hF, st);  chk("wr6_stall", 32'(st), 32'd0);
      cpu_write(8'd45, 32'h45454545, 4'hF, st); chk("wr45_stall", 32'(st), 32'd0);
      cpu_write(8'd44, 32'h44444444, 4'hF, st);

      // JTAG load and read of address 5
      pulse(1'b1, 1'b0, 1'b0, jdo_a(10'd5, 1'b1));
      chk("ld_ready_n0", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("ld_ready_n1", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("ld_mondreg", MonDReg, 32'hDEADBEEF);
      chk("ld_ready_n2", {31'd0, monitor_ready}, 32'd1);
      chk("ld_error", {31'd0, monitor_error}, 32'd0);

      // Auto-increment read of address 6
      pulse(1'b0, 1'b0, 1'b1, 38'd0);
      chk("ai_ready_n0", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("ai_ready_n1", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("ai_ready_n2", {31'd0, monitor_ready}, 32'd1);
      chk("ai_mondreg", MonDReg, 32'hCAFEF00D);

      // JTAG burst write then CPU read-back
      pulse(1'b1, 1'b0, 1'b0, jdo_a(10'd0, 1'b0));
      @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h11)); @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h22)); @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h33)); @(negedge clk);
      cpu_read(8'd0, rd, st); chk("bw_rd0", rd, 32'h11); chk("bw_rd0_stall", 32'(st), 32'd1);
      cpu_read(8'd1, rd, st); chk("bw_rd1", rd, 32'h22); chk("bw_rd1_stall", 32'(st), 32'd1);
      cpu_read(8'd2, rd, st); chk("bw_rd2", rd, 32'h33); chk("bw_rd2_stall", 32'(st), 32'd1);

      // Out-of-range read and write at addresses 300/301
      pulse(1'b1, 1'b0, 1'b0, jdo_a(10'd300, 1'b1));
      @(negedge clk); @(negedge clk);
      chk("oor_mondreg", MonDReg, 32'd0);
      chk("oor_error", {31'd0, monitor_error}, 32'd1);
      chk("oor_ready", {31'd0, monitor_ready}, 32'd1);
      pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h0BAD0BAD)); @(negedge clk);
      cpu_read(8'd45, rd, st); chk("oor_ram45", rd, 32'h45454545);
      cpu_read(8'd44, rd, st); chk("oor_ram44", rd, 32'h44444444);
      chk("oor_error_hold", {31'd0, monitor_error}, 32'd1);
      pulse(1'b1, 1'b0, 1'b0, jdo_a(10'd7, 1'b0));
      chk("oor_error_clr", {31'd0, monitor_error}, 32'd0);
      @(negedge clk);

      // Contention: JTAG write to 7 pending while CPU writes 7
      pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h5A5A5A5A));
      cpu_write(8'd7, 32'hA5A5A5A5, 4'hF, st);
      chk("ct_stall", 32'(st), 32'd1);
      cpu_read(8'd7, rd, st); chk("ct_ram7", rd, 32'hA5A5A5A5);
      cpu_write(8'd7, 32'h000000FF, 4'b0001, st);
      cpu_read(8'd7, rd, st); chk("be_ram7", rd, 32'hA5A5A5FF);

      // Simultaneous _a and _b: _a loads, error flagged
      pulse(1'b1, 1'b0, 1'b0, jdo_a(10'd5, 1'b1));
      @(negedge clk); @(negedge clk);
      chk("ab_pre_mondreg", MonDReg, 32'hDEADBEEF);
      pulse(1'b1, 1'b1, 1'b0, jdo_a(10'd6, 1'b0));
      chk("ab_error", {31'd0, monitor_error}, 32'd1);
      chk("ab_ready", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);

      // Reset while in J_RD
      pulse(1'b0, 1'b0, 1'b1, 38'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mr_mondreg", MonDReg, 32'd0);
      chk("mr_ready", {31'd0, monitor_ready}, 32'd0);
      chk("mr_error", {31'd0, monitor_error}, 32'd0);
      chk("mr_wait", {31'd0, avs_waitrequest}, 32'd1);
      chk("mr_readdata", avs_readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mr_no_ready", {31'd0, monitor_ready}, 32'd0);
      end
      cpu_read(8'd5, rd, st); chk("mr_ram_kept", rd, 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
